mem_port_arbiter: RTL and testbench

//  Shares the single off-chip memory port between the I-cache miss path and the D-cache miss/store path.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_timer.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter: FSM state and
// transaction-owner encodings, default abort limit, timer width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Bits needed to hold 0..term inclusive.
  function automatic int timer_width(input int term);
    return (term < 2) ? 1 : $clog2(term + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Wait-cycle counter for the arbiter: synchronous clear, count enable and a
// terminal-count flag that fires on the cycle the count would reach TERM.
module mem_port_arbiter_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TERM = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int W = timer_width(TERM);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise count up and saturate at TERM.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != W'(TERM))) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag the edge at which the count would reach TERM.
  assign tc_o = enable_i && (count_q == W'(TERM - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single off-chip memory port between the I-miss and D-miss
// paths, one transaction in flight, D before I, with timeout abort and a
// combinational pipeline stall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic              idone_o,
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] dwdata_i,
  output logic              ddone_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              mem_error_o
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              idone_q, idone_d;
  logic              ddone_q, ddone_d;
  logic              err_q, err_d;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_tc;
  logic              finish;
  logic              abort;

  // The timer runs whenever a transaction is in flight.
  assign tmr_en = (state_q != ST_IDLE);

  mem_port_arbiter_timer #(
    .TERM(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (tmr_clear),
    .enable_i(tmr_en),
    .tc_o    (tmr_tc)
  );

  // Next-state, grant mux and completion handling.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    idone_d   = 1'b0;
    ddone_d   = 1'b0;
    err_d     = 1'b0;
    tmr_clear = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A requester still high during its own Done cycle is the request
        // just served, so nothing is granted while a Done pulse is out.
        if (!(idone_q || ddone_q)) begin
          if (dreq_i) begin
            owner_d   = OWN_D;
            addr_d    = daddr_i;
            we_d      = dwe_i;
            wdata_d   = dwdata_i;
            state_d   = ST_REQ;
            tmr_clear = 1'b1;
          end else if (ireq_i) begin
            owner_d   = OWN_I;
            addr_d    = iaddr_i;
            we_d      = 1'b0;
            wdata_d   = '0;
            state_d   = ST_REQ;
            tmr_clear = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) begin
          state_d   = ST_RESP;
          tmr_clear = 1'b1;
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      ST_RESP: begin
        // A response on the timeout edge still counts as a good completion.
        if (mem_resp_valid_i) begin
          finish = 1'b1;
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (finish || abort) begin
      state_d = ST_IDLE;
      owner_d = OWN_NONE;
      idone_d = (owner_q == OWN_I);
      ddone_d = (owner_q == OWN_D);
      err_d   = abort;
      rdata_d = (abort || we_q) ? '0 : mem_rdata_i;
    end
  end

  // State, request and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      idone_q <= 1'b0;
      ddone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      idone_q <= idone_d;
      ddone_q <= ddone_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_valid_o = (state_q == ST_REQ);
  assign mem_addr_o      = addr_q;
  assign mem_we_o        = we_q;
  assign mem_wdata_o     = wdata_q;
  assign rdata_o         = rdata_q;
  assign idone_o         = idone_q;
  assign ddone_o         = ddone_q;
  assign mem_error_o     = err_q;
  // Stall drops in the Done cycle so the pipeline advances exactly once.
  assign stall_o         = (ireq_i && !idone_q) || (dreq_i && !ddone_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, per-cycle
// compare, directed scenarios with literal expectations and a random soak.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, ready = 1'b0, resp = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, mrdata = '0;
  logic        idone_o, ddone_o, valid_o, we_o, stall_o, err_o;
  logic [31:0] rdata_o, maddr_o, mwdata_o;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ireq_i(ireq), .iaddr_i(iaddr), .idone_o(idone_o),
    .dreq_i(dreq), .dwe_i(dwe), .daddr_i(daddr), .dwdata_i(dwdata), .ddone_o(ddone_o),
    .rdata_o(rdata_o),
    .mem_req_valid_o(valid_o), .mem_req_ready_i(ready), .mem_addr_o(maddr_o),
    .mem_we_o(we_o), .mem_wdata_o(mwdata_o),
    .mem_resp_valid_i(resp), .mem_rdata_i(mrdata),
    .stall_o(stall_o), .mem_error_o(err_o)
  );

  // ---------------- reference model (transaction view) ----------------
  bit          m_busy = 0, m_acc = 0, m_we = 0, m_isd = 0;
  bit          m_idone = 0, m_ddone = 0, m_err = 0, m_was_done = 0;
  int          m_wait = 0;
  int          m_grants = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  task automatic m_complete(input bit aborted);
    m_busy  = 0;
    m_acc   = 0;
    m_idone = !m_isd;
    m_ddone = m_isd;
    m_err   = aborted;
    m_rdata = (aborted || m_we) ? 32'h0 : mrdata;
  endtask

  // Advance the model one clock edge from the inputs that edge sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_acc = 0; m_we = 0; m_isd = 0; m_wait = 0;
      m_idone = 0; m_ddone = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      m_was_done = m_idone || m_ddone;
      m_idone = 0; m_ddone = 0; m_err = 0;
      if (!m_busy) begin
        if (!m_was_done && (dreq || ireq)) begin
          m_busy = 1; m_acc = 0; m_wait = 0; m_grants++;
          m_isd  = dreq;
          m_addr = dreq ? daddr : iaddr;
          m_we   = dreq ? dwe : 1'b0;
          m_wdata = dreq ? dwdata : 32'h0;
        end
      end else if (!m_acc) begin
        if (ready) begin
          m_acc = 1; m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait == TO) m_complete(1);
        end
      end else begin
        if (resp) m_complete(0);
        else begin
          m_wait++;
          if (m_wait == TO) m_complete(1);
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("valid", 32'(valid_o), 32'(m_busy && !m_acc));
    chk("addr", maddr_o, m_addr);
    chk("we", 32'(we_o), 32'(m_we));
    chk("wdata", mwdata_o, m_wdata);
    chk("rdata", rdata_o, m_rdata);
    chk("idone", 32'(idone_o), 32'(m_idone));
    chk("ddone", 32'(ddone_o), 32'(m_ddone));
    chk("error", 32'(err_o), 32'(m_err));
    chk("stall", 32'(stall_o), 32'((ireq && !m_idone) || (dreq && !m_ddone)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic int pick_delay();
    return ($urandom_range(0, 19) == 0) ? TO + 1 : int'($urandom_range(0, 3));
  endfunction

  // soak state
  int          cyc, s_start, n_iraise, n_draise, n_iobs, n_dobs;
  int          rdy_cnt, rdy_tgt, rsp_cnt, rsp_tgt;
  bit          rdy_on, rsp_on, d_want_we;
  logic [31:0] i_want, d_want;

  initial begin
    // 1. Reset with IReq held high
    ireq = 1; iaddr = 32'h40;
    #1 rst_n = 0;
    #2;
    chk("rst_stall", 32'(stall_o), 32'h1);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_idone", 32'(idone_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    step(); step();
    rst_n = 1;
    step();
    chk("rel_valid", 32'(valid_o), 32'h1);
    chk("rel_addr", maddr_o, 32'h40);
    ready = 1; step();
    ready = 0; resp = 1; mrdata = 32'h11111111; step();
    chk("t1_idone", 32'(idone_o), 32'h1);
    chk("t1_rdata", rdata_o, 32'h11111111);
    ireq = 0; resp = 0; step();

    // 2. I read with Ready and Resp each one cycle late
    ireq = 1; iaddr = 32'h100; step();
    step();
    chk("t2_valid_held", 32'(valid_o), 32'h1);
    chk("t2_addr", maddr_o, 32'h100);
    ready = 1; step();
    ready = 0; step();
    chk("t2_stall_wait", 32'(stall_o), 32'h1);
    resp = 1; mrdata = 32'hCAFEF00D; step();
    chk("t2_idone", 32'(idone_o), 32'h1);
    chk("t2_rdata", rdata_o, 32'hCAFEF00D);
    chk("t2_stall_done", 32'(stall_o), 32'h0);
    ireq = 0; resp = 0; step();
    chk("t2_idone_pulse", 32'(idone_o), 32'h0);

    // 3. Simultaneous requests: D store first, then I
    ireq = 1; iaddr = 32'h300;
    dreq = 1; dwe = 1; daddr = 32'h200; dwdata = 32'h12345678;
    step();
    chk("t3_we", 32'(we_o), 32'h1);
    chk("t3_addr_d", maddr_o, 32'h200);
    chk("t3_wdata", mwdata_o, 32'h12345678);
    ready = 1; step();
    ready = 0; resp = 1; mrdata = 32'hDEADBEEF; step();
    chk("t3_ddone", 32'(ddone_o), 32'h1);
    chk("t3_rdata_wr", rdata_o, 32'h0);
    chk("t3_stall_i", 32'(stall_o), 32'h1);
    dreq = 0; dwe = 0; resp = 0; step();
    chk("t3_idle_gap", 32'(valid_o), 32'h0);
    step();
    chk("t3_i_valid", 32'(valid_o), 32'h1);
    chk("t3_i_we", 32'(we_o), 32'h0);
    chk("t3_i_addr", maddr_o, 32'h300);
    ready = 1; step();
    ready = 0; resp = 1; mrdata = 32'hABCD0123; step();
    chk("t3_idone", 32'(idone_o), 32'h1);
    chk("t3_i_rdata", rdata_o, 32'hABCD0123);
    ireq = 0; resp = 0; step();

    // 4. Response timeout
    dreq = 1; dwe = 0; daddr = 32'h400; step();
    ready = 1; step();
    ready = 0;
    for (int k = 0; k < TO - 1; k++) begin
      step();
      chk("t4_ddone_early", 32'(ddone_o), 32'h0);
    end
    step();
    chk("t4_ddone", 32'(ddone_o), 32'h1);
    chk("t4_error", 32'(err_o), 32'h1);
    chk("t4_rdata", rdata_o, 32'h0);
    dreq = 0; step();
    chk("t4_error_pulse", 32'(err_o), 32'h0);

    // 5. Stray response in IDLE, then reset while in RESP
    resp = 1; mrdata = 32'h55555555; step(); step();
    chk("t5_no_idone", 32'(idone_o), 32'h0);
    chk("t5_no_ddone", 32'(ddone_o), 32'h0);
    chk("t5_rdata_kept", rdata_o, 32'h0);
    resp = 0;
    ireq = 1; iaddr = 32'h500; step();
    ready = 1; step();
    ready = 0; ireq = 0;
    #2 rst_n = 0;
    #1;
    compare_all();
    chk("t5_rst_valid", 32'(valid_o), 32'h0);
    chk("t5_rst_addr", maddr_o, 32'h0);
    step();
    #2 rst_n = 1;
    resp = 1; mrdata = 32'h77777777; step();
    chk("t5_post_rst_idone", 32'(idone_o), 32'h0);
    resp = 0; step();

    // 6. Random soak
    s_start = m_grants; cyc = 0;
    n_iraise = 0; n_draise = 0; n_iobs = 0; n_dobs = 0;
    rdy_on = 0; rsp_on = 0; rdy_cnt = 0; rdy_tgt = 0; rsp_cnt = 0; rsp_tgt = 0;
    d_want_we = 0; i_want = '0; d_want = '0;
    while (cyc < 40000 &&
           !((m_grants - s_start >= 1000) && !ireq && !dreq && !m_busy && !m_idone && !m_ddone)) begin
      if (idone_o) n_iobs++;
      if (ddone_o) n_dobs++;
      if (m_idone) begin
        chk("soak_i_rdata", rdata_o, m_err ? 32'h0 : hash(i_want));
        ireq = 0;
      end else if (!ireq && (m_grants - s_start < 1000) && $urandom_range(0, 2) == 0) begin
        ireq = 1; iaddr = {$urandom_range(0, 32'hFFFF), 2'b00}; i_want = iaddr; n_iraise++;
      end
      if (m_ddone) begin
        chk("soak_d_rdata", rdata_o, (m_err || d_want_we) ? 32'h0 : hash(d_want));
        dreq = 0;
      end else if (!dreq && (m_grants - s_start < 1000) && $urandom_range(0, 2) == 0) begin
        dreq = 1; dwe = 1'($urandom_range(0, 1)); daddr = {$urandom_range(0, 32'hFFFF), 2'b00};
        dwdata = $urandom; d_want = daddr; d_want_we = dwe; n_draise++;
      end
      if (m_busy && !m_acc) begin
        if (!rdy_on) begin rdy_on = 1; rdy_cnt = 0; rdy_tgt = pick_delay(); end
        ready = (rdy_cnt >= rdy_tgt); rdy_cnt++;
      end else begin
        rdy_on = 0; ready = ($urandom_range(0, 7) == 0);
      end
      if (m_busy && m_acc) begin
        if (!rsp_on) begin rsp_on = 1; rsp_cnt = 0; rsp_tgt = pick_delay(); end
        resp = (rsp_cnt >= rsp_tgt); rsp_cnt++;
        mrdata = resp ? hash(m_addr) : $urandom;
      end else begin
        rsp_on = 0; resp = ($urandom_range(0, 7) == 0); mrdata = $urandom;
      end
      step();
      cyc++;
    end
    if (cyc >= 40000) begin
      n_assert++; n_fail++;
      $display("FAIL soak_bound: %0d cycles used, soak did not drain", cyc);
    end
    chk("soak_i_one_done", 32'(n_iobs), 32'(n_iraise));
    chk("soak_d_one_done", 32'(n_dobs), 32'(n_draise));
    ready = 0; resp = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
